lc3_control_fsm: RTL and testbench

- Moore-style sequencer for the LC-3 datapath: fetch, decode, execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PSE (pause).
- Drives every datapath gate, load and mux select, plus the SRAM strobes, with a parameterised memory wait.
- Sits beside the datapath in the CPU top; consumes IR[15:0] and BEN_OUT from it.

---
 rtl/lc3_ctrl_pkg.sv | 56 +++++
 rtl/lc3_mem_timer.sv | 28 ++
 rtl/lc3_control_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control sequencer.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_CHK,
        S_BR_TAKE,
        S_JMP,
        S_JSR1,
        S_JSR2,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE_IR1,
        S_PAUSE_IR2
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_PSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/lc3_mem_timer.sv
// Wait counter for SRAM states: cleared on entry, counts up, saturates at the last cycle.
module lc3_mem_timer #(
    parameter int MEM_WAIT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_enable,
    output logic o_done
);

    localparam logic [2:0] LP_LAST = 3'(MEM_WAIT - 1);

    logic [2:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LP_LAST)) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_done = (r_cnt == LP_LAST);

endmodule

// File: rtl/lc3_control_fsm.sv
// Moore sequencer for the LC-3 datapath: fetch, decode and execute with timed SRAM access.
// state       | meaning
// HALTED      | idle after reset, waits for Run
// FETCH1..3   | MAR<-PC, PC++ / SRAM read (MEM_WAIT) / IR<-MDR
// DECODE      | BEN load, dispatch on IR[15:12]
// ADD/AND/NOT | ALU op into DR, set CC
// BR_CHK/TAKE | test BEN / PC<-PC+off9
// JMP         | PC<-BaseR
// JSR1/2      | R7<-PC / PC<-PC+off11
// LDR1..3     | MAR<-BaseR+off6 / SRAM read / DR<-MDR
// STR1..3     | MAR<-BaseR+off6 / MDR<-SR / SRAM write
// PAUSE_IR1/2 | wait Continue high, then low
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        GATEPC,
    output logic        GATEMDR,
    output logic        GATEALU,
    output logic        GATEMARMUX,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_PC,
    output logic        LD_CC,
    output logic        LD_BEN,
    output logic        LD_REG,
    output logic        MIO_EN,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_CE_N,
    output logic        Mem_OE_N,
    output logic        Mem_WE_N,
    output logic        Paused
);

    state_t r_state;
    state_t w_state_next;
    logic   w_mem_done;
    logic   w_timer_start;
    logic   w_timer_enable;
    logic   w_unused_ir;

    // Only the opcode and the immediate flag are consumed here.
    assign w_unused_ir = ^{IR[11:6], IR[4:0]};

    assign w_timer_enable = is_mem_state(r_state);
    assign w_timer_start  = is_mem_state(w_state_next) && (w_state_next != r_state);

    lc3_mem_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_timer (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_start  (w_timer_start),
        .i_enable (w_timer_enable),
        .o_done   (w_mem_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HALTED:    if (Run) w_state_next = S_FETCH1;
            S_FETCH1:    w_state_next = S_FETCH2;
            S_FETCH2:    if (w_mem_done) w_state_next = S_FETCH3;
            S_FETCH3:    w_state_next = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_ADD:  w_state_next = S_ADD;
                    OP_AND:  w_state_next = S_AND;
                    OP_NOT:  w_state_next = S_NOT;
                    OP_BR:   w_state_next = S_BR_CHK;
                    OP_JMP:  w_state_next = S_JMP;
                    OP_JSR:  w_state_next = S_JSR1;
                    OP_LDR:  w_state_next = S_LDR1;
                    OP_STR:  w_state_next = S_STR1;
                    OP_PSE:  w_state_next = S_PAUSE_IR1;
                    default: w_state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR2, S_LDR3:
                         w_state_next = S_FETCH1;
            S_BR_CHK:    w_state_next = BEN ? S_BR_TAKE : S_FETCH1;
            S_JSR1:      w_state_next = S_JSR2;
            S_LDR1:      w_state_next = S_LDR2;
            S_LDR2:      if (w_mem_done) w_state_next = S_LDR3;
            S_STR1:      w_state_next = S_STR2;
            S_STR2:      w_state_next = S_STR3;
            S_STR3:      if (w_mem_done) w_state_next = S_FETCH1;
            S_PAUSE_IR1: if (Continue) w_state_next = S_PAUSE_IR2;
            S_PAUSE_IR2: if (!Continue) w_state_next = S_FETCH1;
            default:     w_state_next = S_HALTED;
        endcase
    end

    always_comb begin
        GATEPC     = 1'b0;
        GATEMDR    = 1'b0;
        GATEALU    = 1'b0;
        GATEMARMUX = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_PC      = 1'b0;
        LD_CC      = 1'b0;
        LD_BEN     = 1'b0;
        LD_REG     = 1'b0;
        MIO_EN     = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        PCMUX      = PCMUX_PC1;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_CE_N   = 1'b1;
        Mem_OE_N   = 1'b1;
        Mem_WE_N   = 1'b1;
        Paused     = 1'b0;
        case (r_state)
            S_FETCH1: begin
                GATEPC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PCMUX_PC1;
                LD_PC  = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                Mem_CE_N = 1'b0;
                Mem_OE_N = 1'b0;
                MIO_EN   = 1'b1;
                LD_MDR   = w_mem_done;
            end
            S_FETCH3: begin
                GATEMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR[5];
                GATEALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (r_state == S_ADD) ? ALUK_ADD :
                          (r_state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR_TAKE: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF9;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_JSR1: begin
                GATEPC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S_JSR2: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF11;
                PCMUX    = PCMUX_ADDER;
                LD_PC    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                GATEMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S_LDR3: begin
                GATEMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data is passed through the ALU from SR = IR[11:9].
            S_STR2: begin
                SR1MUX  = 1'b0;
                ALUK    = ALUK_PASSA;
                GATEALU = 1'b1;
                MIO_EN  = 1'b0;
                LD_MDR  = 1'b1;
            end
            S_STR3: begin
                Mem_CE_N = 1'b0;
                Mem_WE_N = 1'b0;
            end
            S_PAUSE_IR1, S_PAUSE_IR2: Paused = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed and random-program bench for lc3_control_fsm, checked cycle by cycle against a micro-op model.
module tb_lc3_control_fsm;

    localparam int MW = 2;

    typedef struct packed {
        logic       gatepc;
        logic       gatemdr;
        logic       gatealu;
        logic       gatemarmux;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_cc;
        logic       ld_ben;
        logic       ld_reg;
        logic       mio_en;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic       paused;
    } ovec_t;

    typedef struct {
        ovec_t v;
        string nm;
    } exp_t;

    localparam ovec_t IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0};

    logic        Clk, Reset, Run, Continue, BEN;
    logic [15:0] IR;
    logic        GATEPC, GATEMDR, GATEALU, GATEMARMUX;
    logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC, LD_BEN, LD_REG;
    logic        MIO_EN, DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        Mem_CE_N, Mem_OE_N, Mem_WE_N, Paused;

    lc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .GATEPC(GATEPC), .GATEMDR(GATEMDR), .GATEALU(GATEALU), .GATEMARMUX(GATEMARMUX),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_CC(LD_CC),
        .LD_BEN(LD_BEN), .LD_REG(LD_REG), .MIO_EN(MIO_EN), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_CE_N(Mem_CE_N), .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N), .Paused(Paused)
    );

    ovec_t act;
    assign act = {GATEPC, GATEMDR, GATEALU, GATEMARMUX, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_CC,
                  LD_BEN, LD_REG, MIO_EN, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, PCMUX, ADDR2MUX,
                  ALUK, Mem_CE_N, Mem_OE_N, Mem_WE_N, Paused};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expectation ring: stimulus owns wr_ptr and the entries, the checker owns rd_ptr.
    exp_t       exp_buf [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         n_vec  = 0;
    int         n_mis  = 0;

    always @(negedge Clk) begin
        if (rd_ptr != wr_ptr) begin
            n_vec = n_vec + 1;
            if (act !== exp_buf[rd_ptr].v) begin
                n_mis = n_mis + 1;
                $display("FAIL %s @%0t: got %07h want %07h", exp_buf[rd_ptr].nm, $time,
                         act, exp_buf[rd_ptr].v);
            end
            rd_ptr = rd_ptr + 8'd1;
        end
        if (!Reset) begin
            n_vec = n_vec + 1;
            if ($countones({GATEPC, GATEMDR, GATEALU, GATEMARMUX}) > 1) begin
                n_mis = n_mis + 1;
                $display("FAIL bus_onehot @%0t: got gates %b want at most one",
                         $time, {GATEPC, GATEMDR, GATEALU, GATEMARMUX});
            end
        end
    end

    task automatic push(input ovec_t v, input string nm);
        exp_buf[wr_ptr].v  = v;
        exp_buf[wr_ptr].nm = nm;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Wait until every pushed expectation is checked, then land #1 after the next rising edge.
    task automatic drain();
        int n;
        n = 0;
        while (rd_ptr != wr_ptr) begin
            @(negedge Clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL drain_timeout: got %0d pending want 0", 8'(wr_ptr - rd_ptr));
                $fatal(1);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic push_read(input string nm);
        ovec_t v;
        for (int i = 0; i < MW; i++) begin
            v = IDLE;
            v.ce_n = 1'b0;
            v.oe_n = 1'b0;
            v.mio_en = 1'b1;
            v.ld_mdr = (i == MW - 1);
            push(v, nm);
        end
    endtask

    task automatic push_fetch();
        ovec_t v;
        v = IDLE; v.gatepc = 1'b1; v.ld_mar = 1'b1; v.ld_pc = 1'b1;
        push(v, "fetch_pc");
        push_read("fetch_read");
        v = IDLE; v.gatemdr = 1'b1; v.ld_ir = 1'b1;
        push(v, "fetch_ir");
        v = IDLE; v.ld_ben = 1'b1;
        push(v, "decode");
    endtask

    task automatic push_addr_calc(input string nm);
        ovec_t v;
        v = IDLE; v.sr1mux = 1'b1; v.addr1mux = 1'b1; v.addr2mux = 2'b01;
        v.gatemarmux = 1'b1; v.ld_mar = 1'b1;
        push(v, nm);
    endtask

    // Model of one non-pause instruction: fetch/decode then its execute micro-ops.
    task automatic push_instr(input logic [15:0] ir, input logic ben);
        ovec_t v;
        push_fetch();
        v = IDLE;
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                v.sr1mux = 1'b1; v.sr2mux = ir[5]; v.gatealu = 1'b1;
                v.ld_reg = 1'b1; v.ld_cc = 1'b1;
                v.aluk = (ir[15:12] == 4'h1) ? 2'b00 : (ir[15:12] == 4'h5) ? 2'b01 : 2'b10;
                push(v, "alu_op");
            end
            4'h0: begin
                push(IDLE, "br_check");
                if (ben) begin
                    v.addr2mux = 2'b10; v.pcmux = 2'b10; v.ld_pc = 1'b1;
                    push(v, "br_take");
                end
            end
            4'hC: begin
                v.sr1mux = 1'b1; v.addr1mux = 1'b1; v.pcmux = 2'b10; v.ld_pc = 1'b1;
                push(v, "jmp");
            end
            4'h4: begin
                v.gatepc = 1'b1; v.drmux = 1'b1; v.ld_reg = 1'b1;
                push(v, "jsr_link");
                v = IDLE; v.addr2mux = 2'b11; v.pcmux = 2'b10; v.ld_pc = 1'b1;
                push(v, "jsr_jump");
            end
            4'h6: begin
                push_addr_calc("ldr_addr");
                push_read("ldr_read");
                v.gatemdr = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1;
                push(v, "ldr_wb");
            end
            4'h7: begin
                push_addr_calc("str_addr");
                v.aluk = 2'b11; v.gatealu = 1'b1; v.ld_mdr = 1'b1;
                push(v, "str_data");
                for (int i = 0; i < MW; i++) begin
                    v = IDLE; v.ce_n = 1'b0; v.we_n = 1'b0;
                    push(v, "str_write");
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic ben);
        IR = ir;
        BEN = ben;
        push_instr(ir, ben);
        drain();
    endtask

    // Pause: h1 extra cycles with Continue low, then Continue high for h2+1 cycles.
    task automatic run_pause(input int h1, input int h2);
        ovec_t p;
        p = IDLE; p.paused = 1'b1;
        IR = 16'hD000;
        push_fetch();
        for (int i = 0; i < h1; i++) push(p, "pause_wait");
        drain();
        Continue = 1'b1;
        push(p, "pause_wait");
        drain();
        for (int i = 0; i < h2; i++) begin
            push(p, "pause_release");
            drain();
        end
        Continue = 1'b0;
        push(p, "pause_release");
        drain();
    endtask

    initial begin
        int n;
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; IR = 16'h1283; BEN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        Run = 1'b1;
        n = 0;
        while (Mem_CE_N !== 1'b0) begin
            @(posedge Clk);
            #1;
            n++;
            if (n > 10) begin
                $display("FAIL reach_fetch_read: got CE_N %b want 0", Mem_CE_N);
                $fatal(1);
            end
        end
        // Asynchronous reset in the middle of the SRAM read.
        #2;
        Reset = 1'b1;
        Run = 1'b0;
        push('{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "reset_mid_read");
        drain();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) push('{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "halted");
        drain();

        // Run=1: one more HALTED cycle, then a hand-computed ADD R1,R2,R3 sequence (6 cycles).
        Run = 1'b1;
        IR = 16'h1283;
        push('{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "halted_run");
        push('{gatepc: 1'b1, ld_mar: 1'b1, ld_pc: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_fetch1");
        push('{mio_en: 1'b1, we_n: 1'b1, default: '0}, "lit_read1");
        push('{mio_en: 1'b1, ld_mdr: 1'b1, we_n: 1'b1, default: '0}, "lit_read2");
        push('{gatemdr: 1'b1, ld_ir: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_fetch3");
        push('{ld_ben: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_decode");
        push('{sr1mux: 1'b1, gatealu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_add");
        drain();
        Run = 1'b0;

        // Next FETCH1 must follow ADD directly; pinned literally here.
        IR = 16'h0405;
        BEN = 1'b1;
        push('{gatepc: 1'b1, ld_mar: 1'b1, ld_pc: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_fetch1_after_add");
        push_read("fetch_read");
        push('{gatemdr: 1'b1, ld_ir: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_fetch3");
        push('{ld_ben: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_decode");
        push('{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_br_chk");
        push('{addr2mux: 2'b10, pcmux: 2'b10, ld_pc: 1'b1, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, default: '0}, "lit_br_take");
        drain();

        run_instr(16'h0405, 1'b0);
        run_instr(16'h7284, 1'b0);
        run_instr(16'h5262, 1'b1);
        run_instr(16'h967F, 1'b0);
        run_instr(16'hC080, 1'b0);
        run_instr(16'h4803, 1'b0);
        run_instr(16'h6284, 1'b0);
        run_instr(16'h8000, 1'b1);
        run_pause(9, 1);
        run_instr(16'h1283, 1'b0);

        for (int k = 0; k < 1400; k++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (r[15:12] == 4'hD) run_pause(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else run_instr(r, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
